// File: rtl/in_port_buffer.sv
// ----------------------------------------------------------------------------
// in_port_buffer
//
// Input-port flit buffer for a 2-D mesh router. Incoming flits are routed
// with dimension-weighted XY logic at write time and the resulting one-hot
// output request is stored alongside each flit. The oldest flit and its
// request are presented on registered outputs. An output switch removes the
// head by returning a matching single-bit grant_clear.
//
// Parameters
//   DATA_WIDTH : flit width in bits
//   FIFO_DEPTH : flit slots (power of two, >= 4)
//   COORD_W    : width of each destination coordinate
//   POS_X/POS_Y: coordinates of this router
//
// Ports
//   clk          : clock, all state on the rising edge
//   rst          : asynchronous active-low reset
//   in_flit      : link flit, dest_x = [COORD_W-1:0], dest_y = [2*COORD_W-1:COORD_W]
//   in_valid     : in_flit present this cycle
//   busy         : backpressure to the upstream output switch
//   head_flit    : oldest stored flit
//   route_valid  : one-hot request of the head (0 N, 1 E, 2 S, 3 W, 4 Local), 0 if empty
//   grant_clear  : per-output-switch clear for this input
//   overflow_err : sticky, a flit was dropped
//   proto_err    : sticky, an illegal clear was received
//   fwd_count    : popped-flit counter (only with INPORT_STATS_EN)
//   drop_count   : dropped-flit counter (only with INPORT_STATS_EN)
//
// Build option
//   INPORT_STATS_EN : when defined, fwd_count/drop_count are live 32-bit
//                     wrapping counters; otherwise both are tied to 0.
// ----------------------------------------------------------------------------
module in_port_buffer #(
  parameter int DATA_WIDTH = 288,
  parameter int FIFO_DEPTH = 4,
  parameter int COORD_W    = 4,
  parameter int POS_X      = 0,
  parameter int POS_Y      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_flit,
  input  logic                  in_valid,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] head_flit,
  output logic [4:0]            route_valid,
  input  logic [4:0]            grant_clear,
  output logic                  overflow_err,
  output logic                  proto_err,
  output logic [31:0]           fwd_count,
  output logic [31:0]           drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]   L_FULL    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   L_BUSY_TH = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [COORD_W-1:0] L_POS_X   = COORD_W'(POS_X);
  localparam logic [COORD_W-1:0] L_POS_Y   = COORD_W'(POS_Y);

  localparam logic [4:0] R_N = 5'b00001;
  localparam logic [4:0] R_E = 5'b00010;
  localparam logic [4:0] R_S = 5'b00100;
  localparam logic [4:0] R_W = 5'b01000;
  localparam logic [4:0] R_L = 5'b10000;

  // Storage (no reset: contents are discarded by clearing the pointers)
  logic [DATA_WIDTH-1:0] r_mem       [FIFO_DEPTH];
  logic [4:0]            r_route_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_head_flit;
  logic [4:0]            r_route_valid;
  logic                  r_overflow_err;
  logic                  r_proto_err;

  logic [COORD_W-1:0] w_dest_x;
  logic [COORD_W-1:0] w_dest_y;
  logic [COORD_W:0]   w_dist_x;
  logic [COORD_W:0]   w_dist_y;
  logic [4:0]         w_x_dir;
  logic [4:0]         w_y_dir;
  logic [4:0]         w_in_route;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic               w_illegal;
  logic [PTR_W-1:0]   w_rd_ptr_inc;

  // --------------------------------------------------------------------------
  // Route computation for the incoming flit
  // --------------------------------------------------------------------------
  assign w_dest_x = in_flit[COORD_W-1:0];
  assign w_dest_y = in_flit[2*COORD_W-1:COORD_W];

  always_comb begin
    w_dist_x   = (w_dest_x > L_POS_X) ? ({1'b0, w_dest_x} - {1'b0, L_POS_X})
                                      : ({1'b0, L_POS_X} - {1'b0, w_dest_x});
    w_dist_y   = (w_dest_y > L_POS_Y) ? ({1'b0, w_dest_y} - {1'b0, L_POS_Y})
                                      : ({1'b0, L_POS_Y} - {1'b0, w_dest_y});
    w_x_dir    = (w_dest_x > L_POS_X) ? R_E : R_W;
    w_y_dir    = (w_dest_y < L_POS_Y) ? R_N : R_S;
    w_in_route = R_L;
    if (w_dest_x == L_POS_X && w_dest_y == L_POS_Y) begin
      w_in_route = R_L;
    end else if (w_dest_x == L_POS_X) begin
      w_in_route = w_y_dir;
    end else if (w_dest_y == L_POS_Y) begin
      w_in_route = w_x_dir;
    end else if (w_dist_x >= w_dist_y) begin
      // Larger distance wins; a tie goes to the X axis.
      w_in_route = w_x_dir;
    end else begin
      w_in_route = w_y_dir;
    end
  end

  // --------------------------------------------------------------------------
  // Push / pop decisions
  // --------------------------------------------------------------------------
  assign w_full  = (r_count == L_FULL);
  assign w_empty = (r_count == '0);

  // route_valid is one-hot when occupied and zero when empty, so an exact
  // match is a legal single-bit clear of a non-empty FIFO; anything else
  // non-zero is a protocol error and does not pop.
  assign w_pop     = (grant_clear != 5'b0) && (grant_clear == r_route_valid);
  assign w_illegal = (grant_clear != 5'b0) && !w_pop;
  assign w_push    = in_valid && (!w_full || w_pop);
  assign w_drop    = in_valid && !w_push;

  assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);

  // --------------------------------------------------------------------------
  // Flit storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]       <= in_flit;
      r_route_mem[r_wr_ptr] <= w_in_route;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy, head registers and sticky errors
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_head_flit    <= '0;
      r_route_valid  <= '0;
      r_overflow_err <= 1'b0;
      r_proto_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      // The head is a register copy of slot rd_ptr. On a pop the successor
      // is read ahead from storage; if the FIFO held only the popped flit,
      // a same-cycle push bypasses straight into the head.
      if (w_pop) begin
        if (r_count > CNT_W'(1)) begin
          r_head_flit   <= r_mem[w_rd_ptr_inc];
          r_route_valid <= r_route_mem[w_rd_ptr_inc];
        end else if (w_push) begin
          r_head_flit   <= in_flit;
          r_route_valid <= w_in_route;
        end else begin
          r_route_valid <= 5'b0;  // head_flit holds its last value
        end
      end else if (w_push && w_empty) begin
        r_head_flit   <= in_flit;
        r_route_valid <= w_in_route;
      end

      if (w_drop) begin
        r_overflow_err <= 1'b1;
      end
      if (w_illegal) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  // Threshold at DEPTH-1 leaves one slot for the flit the upstream switch
  // may already have issued before it sees busy.
  assign busy         = (r_count >= L_BUSY_TH);
  assign head_flit    = r_head_flit;
  assign route_valid  = r_route_valid;
  assign overflow_err = r_overflow_err;
  assign proto_err    = r_proto_err;

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
`ifdef INPORT_STATS_EN
  logic [31:0] r_fwd_count;
  logic [31:0] r_drop_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fwd_count  <= 32'd0;
      r_drop_count <= 32'd0;
    end else begin
      if (w_pop) begin
        r_fwd_count <= r_fwd_count + 32'd1;
      end
      if (w_drop) begin
        r_drop_count <= r_drop_count + 32'd1;
      end
    end
  end

  assign fwd_count  = r_fwd_count;
  assign drop_count = r_drop_count;
`else
  assign fwd_count  = 32'd0;
  assign drop_count = 32'd0;
`endif

endmodule
